seven_seg_scan_decoder: RTL and testbench

Recovers BCD digit codes from a multiplexed, scanned seven-segment display bus. This is the inverse of the team's BCD-to-seven-segment decoder. It samples segment patterns together with a one-hot digit strobe and requires each pattern to be stable before capture. Decoded digits are assembled into a full frame and handed downstream over a valid/ready handshake. It sits on the display side of the decoder chain, for self-check and for loop-back observation of driven displays.

---
 rtl/seven_seg_pkg.sv | 43 ++++
 rtl/seg7_pattern_decode.sv | 34 +++
 rtl/seven_seg_scan_decoder.sv | 132 +++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment bit ordering, glyph patterns,
// scan FSM states and the decoded-pattern record.
package seven_seg_pkg;

    // Segment a is the MSB of the 7-bit bus, g the LSB.
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b0011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1110011;
    localparam logic [6:0] SEG_A     = 7'b0001101;
    localparam logic [6:0] SEG_B     = 7'b0011001;
    localparam logic [6:0] SEG_C     = 7'b0100011;
    localparam logic [6:0] SEG_D     = 7'b1001011;
    localparam logic [6:0] SEG_E     = 7'b0001111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        WAIT_SEL,
        SETTLE,
        HELD
    } scan_state_t;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       err;
    } seg_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to BCD/hex code decoder; dark and
// unrecognised patterns both yield code F, flagged by blank or err.
module seg7_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0]  i_seg,
    output seg_decode_t o_dec
);

    always_comb begin
        // NOTE: assign every output a default before the case so no path leaves it unassigned (no latch).
        o_dec = '{code: 4'hF, blank: 1'b0, err: 1'b0};
        case (i_seg)
            SEG_0:     o_dec.code = 4'h0;
            SEG_1:     o_dec.code = 4'h1;
            SEG_2:     o_dec.code = 4'h2;
            SEG_3:     o_dec.code = 4'h3;
            SEG_4:     o_dec.code = 4'h4;
            SEG_5:     o_dec.code = 4'h5;
            SEG_6:     o_dec.code = 4'h6;
            SEG_7:     o_dec.code = 4'h7;
            SEG_8:     o_dec.code = 4'h8;
            SEG_9:     o_dec.code = 4'h9;
            SEG_A:     o_dec.code = 4'hA;
            SEG_B:     o_dec.code = 4'hB;
            SEG_C:     o_dec.code = 4'hC;
            SEG_D:     o_dec.code = 4'hD;
            SEG_E:     o_dec.code = 4'hE;
            SEG_BLANK: o_dec.blank = 1'b1;
            default:   o_dec.err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers a frame of digit codes from a scanned seven-segment bus: each
// digit is captured after STABLE_CYCLES identical samples, then the full
// frame is offered downstream on a valid/ready handshake.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_i,
    input  logic [DIGITS-1:0]     dig_sel_i,
    output logic                  frame_valid_o,
    input  logic                  frame_ready_i,
    output logic [4*DIGITS-1:0]   frame_code_o,
    output logic [DIGITS-1:0]     frame_blank_o,
    output logic [DIGITS-1:0]     frame_err_o,
    output logic                  overrun_o
);

    scan_state_t               r_state;
    scan_state_t               w_state_next;
    logic [7:0]                r_count;
    logic [7:0]                w_count_next;
    logic [6:0]                r_seg;
    logic [DIGITS-1:0]         r_sel;
    logic                      w_capture;
    logic                      w_changed;
    logic                      w_one_hot;
    seg_decode_t               w_dec;

    seg_decode_t [DIGITS-1:0]  r_slot;
    logic [DIGITS-1:0]         r_mask;
    logic                      w_mask_full;
    logic                      w_load;

    logic                      r_valid;
    logic [4*DIGITS-1:0]       r_code;
    logic [DIGITS-1:0]         r_blank;
    logic [DIGITS-1:0]         r_err;
    logic                      r_overrun;

    // The decoder sees the previous sample; on a capture edge it equals seg_i.
    seg7_pattern_decode u_decode (
        .i_seg (r_seg),
        .o_dec (w_dec)
    );

    assign w_changed = (seg_i != r_seg) || (dig_sel_i != r_sel);
    assign w_one_hot = $onehot(dig_sel_i);

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_capture    = 1'b0;
        if (!w_one_hot) begin
            w_state_next = WAIT_SEL;
            w_count_next = 8'd0;
        end else if (w_changed) begin
            // This edge is the first of the run of identical samples.
            w_state_next = SETTLE;
            w_count_next = 8'd1;
        end else if (r_state == SETTLE) begin
            if (r_count == 8'(STABLE_CYCLES - 1)) begin
                w_capture    = 1'b1;
                w_state_next = HELD;
            end else begin
                w_count_next = r_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_SEL;
            r_count <= 8'd0;
            r_seg   <= '0;
            r_sel   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_seg   <= seg_i;
            r_sel   <= dig_sel_i;
        end
    end

    assign w_mask_full = &r_mask;
    assign w_load      = w_mask_full && (!r_valid || frame_ready_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot array is small and its reset contents are observable, so it is cleared like any register.
            r_slot    <= '0;
            r_mask    <= '0;
            r_valid   <= 1'b0;
            r_code    <= '0;
            r_blank   <= '0;
            r_err     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_valid <= 1'b1;
                for (int n = 0; n < DIGITS; n++) begin
                    r_code[4*n +: 4] <= r_slot[n].code;
                    r_blank[n]       <= r_slot[n].blank;
                    r_err[n]         <= r_slot[n].err;
                end
            end else if (w_mask_full) begin
                r_overrun <= 1'b1;
            end else if (r_valid && frame_ready_i) begin
                r_valid <= 1'b0;
            end
            // A capture on the completing edge starts the next frame's mask.
            r_mask <= (w_mask_full ? '0 : r_mask) | (w_capture ? r_sel : '0);
            for (int n = 0; n < DIGITS; n++) begin
                if (w_capture && r_sel[n]) begin
                    r_slot[n] <= w_dec;
                end
            end
        end
    end

    assign frame_valid_o = r_valid;
    assign frame_code_o  = r_code;
    assign frame_blank_o = r_blank;
    assign frame_err_o   = r_err;
    assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench: directed scans plus random scanning, compared every
// cycle against a behavioural model built from the capture and frame rules.
module tb_seven_seg_scan_decoder;

    localparam int DIGITS = 4;
    localparam int S      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  sel = '0;
    logic        ready = 1'b0;
    logic        frame_valid_o;
    logic [15:0] frame_code_o;
    logic [3:0]  frame_blank_o;
    logic [3:0]  frame_err_o;
    logic        overrun_o;

    seven_seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_i         (seg),
        .dig_sel_i     (sel),
        .frame_valid_o (frame_valid_o),
        .frame_ready_i (ready),
        .frame_code_o  (frame_code_o),
        .frame_blank_o (frame_blank_o),
        .frame_err_o   (frame_err_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Glyph table indexed by code value 0..E.
    logic [6:0] pat [15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
                             7'b1111111, 7'b1110011, 7'b0001101, 7'b0011001,
                             7'b0100011, 7'b1001011, 7'b0001111};

    // Returns {code, blank, err}.
    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 15; i++) begin
            if (s == pat[i]) return {i[3:0], 2'b00};
        end
        if (s == 7'b0000000) return {4'hF, 2'b10};
        return {4'hF, 2'b01};
    endfunction

    // Reference model state.
    logic [6:0]  m_prev_seg;
    logic [3:0]  m_prev_sel;
    int          m_run;
    logic [3:0]  m_mask;
    logic [5:0]  m_slot [4];
    logic        m_valid;
    logic [15:0] m_code;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    logic        m_overrun;

    task automatic model_reset();
        m_prev_seg = '0;
        m_prev_sel = '0;
        m_run      = 0;
        m_mask     = '0;
        for (int n = 0; n < 4; n++) m_slot[n] = '0;
        m_valid    = 1'b0;
        m_code     = '0;
        m_blank    = '0;
        m_err      = '0;
        m_overrun  = 1'b0;
    endtask

    task automatic model_edge();
        logic       full;
        logic       cap;
        logic [5:0] dec;
        if (seg == m_prev_seg && sel == m_prev_sel) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev_seg = seg;
        m_prev_sel = sel;
        cap  = ($countones(sel) == 1) && (m_run == S);
        full = (m_mask == 4'hF);
        m_overrun = 1'b0;
        if (full) begin
            if (!m_valid || ready) begin
                m_valid = 1'b1;
                for (int n = 0; n < 4; n++) begin
                    m_code[4*n +: 4] = m_slot[n][5:2];
                    m_blank[n]       = m_slot[n][1];
                    m_err[n]         = m_slot[n][0];
                end
            end else begin
                m_overrun = 1'b1;
            end
            m_mask = '0;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
        if (cap) begin
            dec = ref_decode(seg);
            for (int n = 0; n < 4; n++) begin
                if (sel[n]) begin
                    m_slot[n] = dec;
                    m_mask[n] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".valid"},   frame_valid_o, m_valid);
        check({tag, ".code"},    frame_code_o,  m_code);
        check({tag, ".blank"},   frame_blank_o, m_blank);
        check({tag, ".err"},     frame_err_o,   m_err);
        check({tag, ".overrun"}, overrun_o,     m_overrun);
    endtask

    // Per-scenario observations of the DUT, checked against constants.
    int          step_cnt;
    int          n_valid;
    int          n_over;
    int          first_valid_step;
    logic [15:0] last_code;
    logic [3:0]  last_blank;
    logic [3:0]  last_err;

    task automatic clear_obs();
        step_cnt         = 0;
        n_valid          = 0;
        n_over           = 0;
        first_valid_step = -1;
        last_code        = '0;
        last_blank       = '0;
        last_err         = '0;
    endtask

    // r_mode: 0/1 fixed ready, 2 random ready.
    task automatic step(input logic [6:0] s, input logic [3:0] d, input int r_mode);
        seg   = s;
        sel   = d;
        ready = (r_mode == 2) ? ($urandom_range(0, 3) != 0) : r_mode[0];
        @(posedge clk);
        model_edge();
        #1;
        compare("cyc");
        step_cnt++;
        if (frame_valid_o) begin
            n_valid++;
            if (first_valid_step < 0) first_valid_step = step_cnt;
            last_code  = frame_code_o;
            last_blank = frame_blank_o;
            last_err   = frame_err_o;
        end
        if (overrun_o) n_over++;
    endtask

    task automatic hold(input int digit, input logic [6:0] s, input int cycles, input int r_mode);
        logic [3:0] d;
        d = 4'b0001 << digit;
        repeat (cycles) step(s, d, r_mode);
    endtask

    // Asserts reset between clock edges and checks it acts without an edge.
    task automatic do_reset();
        #2;
        seg = '0;
        sel = '0;
        rst = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        @(posedge clk);
        #1;
        compare("rst_held");
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        int         r;

        model_reset();
        #2;
        rst = 1'b1;
        #1;
        compare("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean scan 1,2,3,4: digit 3 captures on step 22, frame on step 23.
        clear_obs();
        hold(0, pat[1], 6, 1);
        hold(1, pat[2], 6, 1);
        hold(2, pat[3], 6, 1);
        hold(3, pat[4], 6, 1);
        repeat (2) step(7'b0, 4'b0, 1);
        check("clean.n_valid", n_valid, 1);
        check("clean.latency", first_valid_step, 23);
        check("clean.code", last_code, 16'h4321);
        check("clean.blank", last_blank, 4'b0000);
        check("clean.err", last_err, 4'b0000);

        // Glitch on the last digit must not complete the frame early.
        clear_obs();
        hold(0, pat[5], 5, 1);
        hold(1, pat[6], 5, 1);
        hold(3, pat[9], 5, 1);
        hold(2, pat[7], 3, 1);
        hold(2, pat[8], 3, 1);
        repeat (1) step(7'b0, 4'b0, 1);
        check("glitch.no_frame", n_valid, 0);
        hold(2, pat[8], 4, 1);
        repeat (2) step(7'b0, 4'b0, 1);
        check("glitch.n_valid", n_valid, 1);
        check("glitch.code", last_code, 16'h9865);

        // Blank and error digits, with a multi-hot strobe in between.
        clear_obs();
        hold(0, pat[0], 5, 1);
        hold(1, 7'b0000000, 5, 1);
        repeat (10) step(pat[8], 4'b0011, 1);
        hold(2, 7'b1000001, 5, 1);
        hold(3, pat[14], 5, 1);
        repeat (2) step(7'b0, 4'b0, 1);
        check("blank.n_valid", n_valid, 1);
        check("blank.code", last_code, 16'hEFF0);
        check("blank.blank", last_blank, 4'b0010);
        check("blank.err", last_err, 4'b0100);

        // Backpressure: second frame is dropped, first stays on the outputs.
        clear_obs();
        hold(0, pat[1], 5, 0);
        hold(1, pat[2], 5, 0);
        hold(2, pat[3], 5, 0);
        hold(3, pat[4], 5, 0);
        hold(0, pat[5], 5, 0);
        hold(1, pat[6], 5, 0);
        hold(2, pat[7], 5, 0);
        hold(3, pat[8], 5, 0);
        repeat (3) step(7'b0, 4'b0, 0);
        check("bp.overrun_pulses", n_over, 1);
        check("bp.valid_held", frame_valid_o, 1'b1);
        check("bp.code_held", frame_code_o, 16'h4321);
        step(7'b0, 4'b0, 1);
        check("bp.valid_drop", frame_valid_o, 1'b0);

        // Reset after two captures; the next frame needs four fresh digits.
        clear_obs();
        hold(0, pat[9], 5, 1);
        hold(1, pat[8], 5, 1);
        do_reset();
        hold(2, pat[7], 5, 1);
        hold(3, pat[6], 5, 1);
        check("rstmid.no_frame", n_valid, 0);
        hold(0, pat[9], 5, 1);
        hold(1, pat[8], 5, 1);
        repeat (2) step(7'b0, 4'b0, 1);
        check("rstmid.n_valid", n_valid, 1);
        check("rstmid.code", last_code, 16'h6789);

        // Random scanning with random backpressure and occasional strobe faults.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       s = pat[$urandom_range(0, 14)];
            else if (r == 7) s = 7'b0000000;
            else             s = 7'($urandom);
            if ($urandom_range(0, 9) == 0) d = 4'($urandom);
            else                           d = 4'b0001 << $urandom_range(0, 3);
            repeat ($urandom_range(1, 7)) step(s, d, 2);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
